handshake_eager_fork: RTL
=========================

HANDSHAKE_EAGER_FORK -- requirements
Module: handshake_eager_fork

Interface
REQ-001 Parameter SIZE, default 2: number of output channels, legal range 1..32.
REQ-002 Parameter DATA_TYPE, default 32: data width in bits of the input and of each output channel.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port rst  input  1  reset, synchronous and active-low.
REQ-005 Port ins  input  DATA_TYPE  upstream token data.
REQ-006 Port ins_valid  input  1  upstream token present.
REQ-007 Port ins_ready  output  1  token consumed this cycle.
REQ-008 Port outs  output  SIZE*DATA_TYPE  flattened copies of ins; channel i occupies bits [i*DATA_TYPE +: DATA_TYPE].
REQ-009 Port outs_valid  output  SIZE  per-channel valid; bit i belongs to channel i.
REQ-010 Port outs_ready  input  SIZE  per-channel downstream ready; bit i belongs to channel i.

Function
REQ-011 The block SHALL replicate one input token to all SIZE outputs, letting each output complete independently (eager fork).
REQ-012 The block SHALL hold one state bit per channel, done[i], meaning "channel i has already accepted the current token".
REQ-013 outs[i] SHALL equal ins combinationally on every channel, with zero latency.
REQ-014 outs_valid[i] SHALL equal ins_valid AND NOT done[i], combinationally.
REQ-015 ins_ready SHALL equal the AND over all i of (done[i] OR outs_ready[i]), combinationally.
REQ-016 ins_ready SHALL NOT depend on ins_valid.
REQ-017 A channel transfer occurs when outs_valid[i] and outs_ready[i] are both 1; an input transfer occurs when ins_valid and ins_ready are both 1.
REQ-018 On an input transfer, every done bit SHALL be 0 at the next edge, so the next token is offered to all channels.
REQ-019 Otherwise, done[i] SHALL become done[i] OR (channel-i transfer) at the next edge.
REQ-020 A token SHALL be delivered exactly once per channel: no duplicate and no dropped delivery on any channel.
REQ-021 When all channels are ready in the same cycle, the block SHALL have 0-cycle latency, with no state change.
REQ-022 A sustained throughput of 1 token per cycle SHALL be met when all outs_ready bits are 1.
REQ-023 Upstream SHALL hold ins and ins_valid stable until ins_ready is 1.
REQ-024 If ins_valid falls before the input transfer (protocol violation), done bits SHALL be retained unchanged.
REQ-025 For SIZE=1, the block SHALL behave as a wire: outs=ins, outs_valid=ins_valid, ins_ready=outs_ready, done stays 0.
REQ-026 There SHALL be no wrap-around or counter state; the done vector is the only state.

Reset
REQ-027 While rst=0 at a rising edge, all done bits SHALL become 0.
REQ-028 While rst=0, ins_ready and all outs_valid bits SHALL be driven 0; outs SHALL continue to follow ins.
REQ-029 A reset asserted mid-token SHALL discard partial-delivery state; after release, the held token is re-offered to all channels.
REQ-030 The first cycle after release SHALL behave per REQ-014/015 with done=0.

Structure
REQ-031 SIZE and DATA_TYPE defaults SHALL be defined as constants in the shared handshake constants package; no block-specific typedefs are required.
REQ-032 The block SHALL use one sub-module, eager_fork_register_block, instantiated once per channel.
REQ-033 Each eager_fork_register_block instance SHALL hold one done bit and produce that channel's outs_valid[i] and its "done OR ready" term.
REQ-034 The top level SHALL contain only the AND reduction for ins_ready, the data fan-out and the instance array.

Verification (SIZE=2, DATA_TYPE=32 unless stated)
REQ-035 All ready: ins=0x000000AB, ins_valid=1, outs_ready=11 -> outs_valid=11 and ins_ready=1 in the same cycle, done stays 00, both outs=0x000000AB.
REQ-036 Staggered, cycle 0: ins=0x12345678, outs_ready=01 -> outs_valid=11, ins_ready=0, done becomes 01.
REQ-037 Staggered, cycle 1: outs_ready=10 -> outs_valid=10, ins_ready=1, done becomes 00; channel 0 sees exactly one transfer.
REQ-038 Stall: outs_ready=00 for 5 cycles with ins held at 0xDEADBEEF -> outs_valid=11 and ins_ready=0 every cycle, no transfer.
REQ-039 Back-to-back: tokens 1, 2, 3 with outs_ready=11 -> three input transfers in three consecutive cycles; each channel receives 1, 2, 3 in order.
REQ-040 Reset mid-op: done=01, rst=0 for one cycle -> outs_valid=00 and ins_ready=0 during reset; after release with ins_valid=1, outs_valid=11.
REQ-041 SIZE=3, random outs_ready over 1000 tokens -> per-channel received sequence equals the sent sequence, with no duplicates and no drops.

Source files
------------

// File: rtl/handshake_eager_fork_pkg.sv
`default_nettype none
// ============================================================================
// Module      : handshake_eager_fork_pkg
// Description : Shared handshake constants (default fork width and data width)
// Revision    : 1.0 - initial release
// ============================================================================
package handshake_eager_fork_pkg;

    // Default number of output channels of the eager fork
    localparam int HS_DEFAULT_SIZE      = 2;
    // Default token data width in bits
    localparam int HS_DEFAULT_DATA_TYPE = 32;

endpackage : handshake_eager_fork_pkg
`default_nettype wire

// File: rtl/handshake_eager_fork_register_block.sv
`default_nettype none
// ============================================================================
// Module      : eager_fork_register_block
// Description : Per-channel state of the eager fork. Holds the "already
//               accepted current token" bit for one output channel.
// Revision    : 1.0 - initial release
// ============================================================================
module eager_fork_register_block (
    input  logic clk,
    input  logic rst,            // synchronous, active-low
    input  logic ins_valid,
    input  logic outs_ready,
    input  logic ins_transfer,   // whole token consumed upstream this cycle
    output logic outs_valid,
    output logic done_or_ready
);

    logic done_q;
    logic done_d;

    // Clear on a completed input transfer, otherwise latch a channel transfer
    always_comb begin
        done_d = done_q;
        if (ins_transfer) begin
            done_d = 1'b0;
        end else if (outs_valid && outs_ready) begin
            done_d = 1'b1;
        end
    end

    // Done-bit register; reset drops any partial delivery
    always_ff @(posedge clk) begin
        if (!rst) begin
            done_q <= 1'b0;
        end else begin
            done_q <= done_d;
        end
    end

    // Offer the token only while this channel has not taken it; silent in reset
    assign outs_valid    = rst & ins_valid & ~done_q;
    assign done_or_ready = done_q | outs_ready;

endmodule : eager_fork_register_block
`default_nettype wire

// File: rtl/handshake_eager_fork.sv
`default_nettype none
// ============================================================================
// Module      : handshake_eager_fork
// Description : Eager fork. Replicates each input token to SIZE outputs; each
//               output completes independently, the input is released once
//               every output has accepted the token.
// Revision    : 1.0 - initial release
// ============================================================================
module handshake_eager_fork
    import handshake_eager_fork_pkg::*;
#(
    parameter int SIZE      = HS_DEFAULT_SIZE,
    parameter int DATA_TYPE = HS_DEFAULT_DATA_TYPE
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_TYPE-1:0]      ins,
    input  logic                      ins_valid,
    output logic                      ins_ready,
    output logic [SIZE*DATA_TYPE-1:0] outs,
    output logic [SIZE-1:0]           outs_valid,
    input  logic [SIZE-1:0]           outs_ready
);

    logic [SIZE-1:0] done_or_ready;
    logic            ins_transfer;

    // Input is consumed only when every channel has taken or is taking the token
    assign ins_ready    = rst & (&done_or_ready);
    assign ins_transfer = ins_valid & ins_ready;

    genvar gi;
    generate
        for (gi = 0; gi < SIZE; gi++) begin : g_channel
            // Zero-latency data fan-out
            assign outs[gi*DATA_TYPE +: DATA_TYPE] = ins;

            eager_fork_register_block u_reg (
                .clk           (clk),
                .rst           (rst),
                .ins_valid     (ins_valid),
                .outs_ready    (outs_ready[gi]),
                .ins_transfer  (ins_transfer),
                .outs_valid    (outs_valid[gi]),
                .done_or_ready (done_or_ready[gi])
            );
        end
    endgenerate

endmodule : handshake_eager_fork
`default_nettype wire
